// File: rtl/nco_sched_pkg.sv
// Shared types and helpers for the multi-channel NCO scheduler.
// Holds the width defaults, the issue FSM encoding and the round-robin search.
package nco_sched_pkg;
   localparam int PHASE_W_DEF = 32;
   localparam int XY_W_DEF    = 32;
   localparam int MAX_CH      = 16;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   // First set bit of en[0..n-1] at or after start, searched cyclically; 0 if none set.
   function automatic int unsigned rr_search(input logic [MAX_CH-1:0] en,
                                             input int unsigned       start,
                                             input int unsigned       n);
      int unsigned      idx;
      logic             found;
      logic [MAX_CH-1:0] sh;
      rr_search = 0;
      found     = 1'b0;
      for (int unsigned k = 0; k < MAX_CH; k++) begin
         idx = (start + k >= n) ? start + k - n : start + k;
         sh  = en >> idx;
         if (k < n && !found && sh[0]) begin
            rr_search = idx;
            found     = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/nco_tag_fifo.sv
// In-order FIFO of channel tags for outstanding nco transactions.
// Head and count come straight from registers; push when full or pop when empty is ignored.
module nco_tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [W-1:0]           head
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign head  = mem_q[rd_q];
endmodule

// File: rtl/nco_chan_sched.sv
// Round-robin sharing of one nco core across N_CH phase accumulators, results tagged in order.
// Grant 1 cycle after eligibility, held until ack, <=1 angle per 2 cycles; return path is combinational.
module nco_chan_sched
   import nco_sched_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CH_W    = $clog2(N_CH),
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int XY_W    = XY_W_DEF,
   parameter int DEPTH   = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cfg_we,
   input  logic                   cfg_clr,
   input  logic [CH_W-1:0]        cfg_ch,
   input  logic [PHASE_W-1:0]     cfg_inc,
   input  logic [N_CH-1:0]        ch_en,
   output logic [PHASE_W-1:0]     t_angle_dat,
   output logic                   t_angle_req,
   input  logic                   t_angle_ack,
   input  logic [XY_W-1:0]        i_nco_dat,
   input  logic                   i_nco_req,
   output logic                   i_nco_ack,
   output logic [XY_W-1:0]        r_dat,
   output logic [CH_W-1:0]        r_ch,
   output logic                   r_req,
   input  logic                   r_ack,
   output logic [$clog2(DEPTH):0] outstanding,
   output logic                   err_orphan
);
   state_t             state_q;
   logic [CH_W-1:0]    g_ch_q, rr_q, g_ch_d, rr_d, head;
   logic [PHASE_W-1:0] angle_q;
   logic [PHASE_W-1:0] phase_q [N_CH];
   logic [PHASE_W-1:0] inc_q   [N_CH];
   logic               err_q;
   logic               fifo_full, fifo_empty, ack, grant, pop;

   assign ack    = (state_q == REQ) && t_angle_ack;
   assign grant  = (|ch_en) && !fifo_full;
   assign g_ch_d = CH_W'(rr_search(MAX_CH'(ch_en), 32'(rr_q), N_CH));
   assign rr_d   = (g_ch_q == CH_W'(N_CH - 1)) ? '0 : g_ch_q + CH_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         g_ch_q  <= '0;
         rr_q    <= '0;
         angle_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (grant) begin
               state_q <= REQ;
               g_ch_q  <= g_ch_d;
               angle_q <= phase_q[g_ch_d];
            end
            REQ: if (t_angle_ack) begin
               state_q <= IDLE;
               rr_q    <= rr_d;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign t_angle_req = (state_q == REQ);
   assign t_angle_dat = angle_q;

   // A clear beats the accumulate; a new increment only affects later issues.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CH; i++) begin
            phase_q[i] <= '0;
            inc_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (cfg_clr && cfg_ch == CH_W'(i))
               phase_q[i] <= '0;
            else if (ack && g_ch_q == CH_W'(i))
               phase_q[i] <= phase_q[i] + inc_q[i];
            if (cfg_we && cfg_ch == CH_W'(i))
               inc_q[i] <= cfg_inc;
         end
      end
   end

   nco_tag_fifo #(.W(CH_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (ack),
      .pop     (pop),
      .din     (g_ch_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (outstanding),
      .head    (head)
   );

   // With no tag outstanding a result is orphaned: swallow it and flag.
   assign pop       = i_nco_req && r_ack && !fifo_empty;
   assign r_req     = i_nco_req && !fifo_empty;
   assign r_dat     = i_nco_dat;
   assign r_ch      = head;
   assign i_nco_ack = fifo_empty ? 1'b1 : r_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                       err_q <= 1'b0;
      else if (i_nco_req && fifo_empty)   err_q <= 1'b1;
   end

   assign err_orphan = err_q;
endmodule
